// File: rtl/pipe_pkg.sv
// Shared pipeline constants and instruction-class encoding for the ID-stage hazard logic.
package pipe_pkg;

    localparam int unsigned REG_IDX_W       = 5;
    localparam int unsigned NUM_REGS        = 32;
    localparam int unsigned ZERO_REG        = 31;
    localparam int unsigned DEF_LAT_W       = 3;
    localparam int unsigned DEF_LOAD_LAT    = 1;
    localparam int unsigned DEF_MUL_LAT     = 4;
    localparam int unsigned STALL_CNT_W     = 16;

    typedef enum logic [1:0] {
        CLASS_ALU  = 2'd0,
        CLASS_LOAD = 2'd1,
        CLASS_MUL  = 2'd2,
        CLASS_NONE = 2'd3
    } instr_class_t;

endpackage

// File: rtl/ready_countdown.sv
// One result-readiness countdown: loads a latency, counts down to zero, flags nonzero.
module ready_countdown #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic [LAT_W-1:0] cnt_o,
    output logic             nonzero_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // A new load overrides the decrement of an older pending result.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: per-register forwarding countdowns, RAW/WAW/multiplier hazard stall.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned LAT_W    = DEF_LAT_W,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned MUL_LAT  = DEF_MUL_LAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_IDX_W-1:0]   id_rn,
    input  logic [REG_IDX_W-1:0]   id_rm,
    input  logic                   id_uses_rn,
    input  logic                   id_uses_rm,
    input  logic [REG_IDX_W-1:0]   id_rd,
    input  logic                   id_writes_rd,
    input  logic [1:0]             id_class,
    input  logic                   flush,
    output logic                   stall,
    output logic                   bubble,
    output logic                   mul_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

    instr_class_t           cls;
    logic [LAT_W-1:0]       lat;
    logic [LAT_W-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0]    reg_busy;
    logic [NUM_REGS-1:0]    reg_load;
    logic [LAT_W-1:0]       mul_cnt;
    logic                   mul_nonzero;
    logic                   raw_n;
    logic                   raw_m;
    logic                   waw;
    logic                   mstruct;
    logic                   hazard;
    logic                   issue;
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic [STALL_CNT_W-1:0] stall_count_d;

    assign cls = instr_class_t'(id_class);

    always_comb begin
        lat = '0;
        case (cls)
            CLASS_LOAD: lat = LAT_W'(LOAD_LAT);
            CLASS_MUL:  lat = LAT_W'(MUL_LAT);
            default:    lat = '0;
        endcase
    end

    // A WAW hazard exists only if the older write would land after the new one.
    assign raw_n   = id_uses_rn & (id_rn != ZERO_IDX) & reg_busy[id_rn];
    assign raw_m   = id_uses_rm & (id_rm != ZERO_IDX) & reg_busy[id_rm];
    assign waw     = id_writes_rd & (id_rd != ZERO_IDX) & (cnt[id_rd] > lat);
    assign mstruct = (cls == CLASS_MUL) & (mul_cnt != '0);
    assign hazard  = raw_n | raw_m | waw | mstruct;

    assign stall    = ~reset & id_valid & ~flush & hazard;
    assign bubble   = stall;
    assign mul_busy = ~reset & mul_nonzero;
    assign issue    = id_valid & ~flush & ~stall;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            assign reg_load[r] = 1'b0;
        end else begin : g_arch
            assign reg_load[r] = issue & id_writes_rd & (id_rd == REG_IDX_W'(r));
        end

        ready_countdown #(
            .LAT_W (LAT_W)
        ) u_cnt (
            .clk        (clk),
            .reset      (reset),
            .load_i     (reg_load[r]),
            .load_val_i (lat),
            .cnt_o      (cnt[r]),
            .nonzero_o  (reg_busy[r])
        );
    end

    ready_countdown #(
        .LAT_W (LAT_W)
    ) u_mul_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue & (cls == CLASS_MUL)),
        .load_val_i (LAT_W'(MUL_LAT)),
        .cnt_o      (mul_cnt),
        .nonzero_o  (mul_nonzero)
    );

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios then random traffic against a ready-time model.
module tb_hazard_scoreboard;
    import pipe_pkg::*;

    localparam int LOAD_L = 1;
    localparam int MUL_L  = 4;
    localparam int C_ALU  = 0;
    localparam int C_LOAD = 1;
    localparam int C_MUL  = 2;
    localparam int C_NONE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rn = '0;
    logic [4:0]  id_rm = '0;
    logic        id_uses_rn = 1'b0;
    logic        id_uses_rm = 1'b0;
    logic [4:0]  id_rd = '0;
    logic        id_writes_rd = 1'b0;
    logic [1:0]  id_class = 2'd3;
    logic        flush = 1'b0;
    logic        stall;
    logic        bubble;
    logic        mul_busy;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Model: absolute cycle at which each register's result becomes forwardable.
    int ready [32];
    int mul_ready = 0;
    int cyc = 0;
    int exp_cnt = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rn   (id_uses_rn),
        .id_uses_rm   (id_uses_rm),
        .id_rd        (id_rd),
        .id_writes_rd (id_writes_rd),
        .id_class     (id_class),
        .flush        (flush),
        .stall        (stall),
        .bubble       (bubble),
        .mul_busy     (mul_busy),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int remaining(input int r);
        return (ready[r] > cyc) ? ready[r] - cyc : 0;
    endfunction

    task automatic step(input bit v, input int rn, input int rm, input bit urn, input bit urm,
                        input int rd, input bit wr, input int cls, input bit fl, input bit rst);
        int  lat;
        bit  haz;
        bit  exp_stall;
        bit  exp_mbusy;
        @(negedge clk);
        id_valid     = v;
        id_rn        = 5'(rn);
        id_rm        = 5'(rm);
        id_uses_rn   = urn;
        id_uses_rm   = urm;
        id_rd        = 5'(rd);
        id_writes_rd = wr;
        id_class     = 2'(cls);
        flush        = fl;
        reset        = rst;
        #1;
        lat = (cls == C_LOAD) ? LOAD_L : (cls == C_MUL) ? MUL_L : 0;
        haz = (urn && rn != 31 && remaining(rn) > 0) ||
              (urm && rm != 31 && remaining(rm) > 0) ||
              (wr && rd != 31 && remaining(rd) > lat) ||
              (cls == C_MUL && mul_ready > cyc);
        exp_stall = !rst && v && !fl && haz;
        exp_mbusy = !rst && (mul_ready > cyc);
        check("stall", 32'(stall), 32'(exp_stall));
        check("bubble", 32'(bubble), 32'(exp_stall));
        check("mul_busy", 32'(mul_busy), 32'(exp_mbusy));
        check("stall_count", 32'(stall_count), 32'(exp_cnt));
        @(posedge clk);
        if (rst) begin
            foreach (ready[i]) ready[i] = 0;
            mul_ready = 0;
            exp_cnt   = 0;
        end else begin
            if (exp_stall && exp_cnt < 65535) exp_cnt++;
            if (v && !fl && !exp_stall) begin
                if (wr && rd != 31) ready[rd] = cyc + 1 + lat;
                if (cls == C_MUL) mul_ready = cyc + 1 + MUL_L;
            end
        end
        cyc++;
    endtask

    task automatic ins(input int cls, input int rd, input int rn, input int rm);
        step(1'b1, rn, rm, 1'b1, 1'b1, rd, cls != C_NONE, cls, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, C_NONE, 1'b0, 1'b0);
    endtask

    task automatic rst_cycle();
        step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, C_NONE, 1'b0, 1'b1);
    endtask

    initial begin
        foreach (ready[i]) ready[i] = 0;
        rst_cycle();
        rst_cycle();

        // Load-use: one bubble, then issue.
        ins(C_LOAD, 1, 30, 30);
        ins(C_ALU, 2, 1, 3);
        ins(C_ALU, 2, 1, 3);
        idle();
        check("load_use_stall_count", 32'(stall_count), 32'd1);

        // ALU back-to-back never stalls, same source on both ports.
        ins(C_ALU, 1, 2, 3);
        ins(C_ALU, 4, 1, 1);
        idle();

        // MUL dependent: four stall cycles.
        ins(C_MUL, 5, 2, 3);
        repeat (5) ins(C_ALU, 6, 5, 7);
        idle();
        check("mul_dep_stall_count", 32'(stall_count), 32'd5);

        // Independent MUL blocked by multiplier occupancy.
        ins(C_MUL, 5, 2, 3);
        repeat (5) ins(C_MUL, 8, 9, 10);
        repeat (5) idle();

        // ALU write to a register with a pending MUL result waits for WAW.
        ins(C_MUL, 5, 2, 3);
        repeat (5) ins(C_ALU, 5, 9, 10);
        repeat (5) idle();

        // Zero register never hazards; flushed load records nothing.
        ins(C_LOAD, 31, 2, 3);
        ins(C_ALU, 6, 31, 31);
        step(1'b1, 2, 3, 1'b1, 1'b1, 1, 1'b1, C_LOAD, 1'b1, 1'b0);
        ins(C_ALU, 7, 1, 1);
        ins(C_MUL, 11, 2, 3);
        step(1'b1, 11, 11, 1'b1, 1'b1, 12, 1'b1, C_ALU, 1'b1, 1'b0);

        // Reset mid-flight discards pending MUL.
        ins(C_MUL, 5, 2, 3);
        idle();
        rst_cycle();
        ins(C_ALU, 6, 5, 5);
        ins(C_MUL, 13, 5, 6);
        idle();

        for (int i = 0; i < 3000; i++) begin
            int  rv [3];
            int  cls;
            for (int k = 0; k < 3; k++) begin
                rv[k] = int'($urandom_range(0, 8));
                if (rv[k] == 8) rv[k] = 31;
            end
            cls = int'($urandom_range(0, 3));
            step(($urandom % 8) != 0, rv[0], rv[1], 1'($urandom), 1'($urandom), rv[2],
                 (cls != C_NONE) && (($urandom % 4) != 0), cls,
                 ($urandom % 10) == 0, ($urandom % 250) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
